shift_issue_ctrl: RTL and testbench
===================================

// Module: shift_issue_ctrl
// PURPOSE
//  Upstream issue/return stage for the 32-bit clocked barrel shifter (shifter).
//  Buffers shift commands (operand, amount, rotate) behind a valid/ready port.
//  Issues at most one command per cycle to the shifter. Captures each shifter
//  result after the fixed shifter latency and returns it on a valid/ready port.
//  Credit accounting guarantees a result slot before issue; the shifter never stalls.
// PARAMETERS
//  CMD_DEPTH  4  command FIFO entries (power of 2, >=2)
//  RES_DEPTH  4  result FIFO entries (power of 2, >=2); also the credit pool
//  SH_LAT     1  shifter latency, in edges, from sh_* stable to sh_b valid
// PORTS
//  clock      in   1   single clock, rising edge
//  reset_n    in   1   asynchronous active-low reset
//  in_valid   in   1   command valid
//  in_ready   out  1   command FIFO not full
//  in_data    in   32  operand
//  in_amt     in   5   shift amount 0..31
//  in_rotate  in   1   1 = rotate, 0 = shift
//  sh_a       out  32  to shifter a (registered)
//  sh_sel     out  5   to shifter sel (registered)
//  sh_rotate  out  1   to shifter rotate (registered)
//  sh_b       in   32  from shifter b
//  out_valid  out  1   result FIFO not empty
//  out_ready  in   1   consumer accepts result
//  out_data   out  32  head of result FIFO
//  busy       out  1   any command queued, in flight, or result held
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFOs empty, valid pipe cleared,
//    credits = RES_DEPTH, sh_a = 0, sh_sel = 0, sh_rotate = 0, out_valid = 0,
//    busy = 0. in_ready = 1 while reset_n is low and after release.
//  - Accept: in_valid & in_ready at an edge pushes {in_data, in_amt, in_rotate}.
//  - Issue: cmd FIFO non-empty & credits > 0 at an edge -> pop the head, load
//    sh_*, push 1 into the valid pipe, decrement credits. Otherwise sh_* hold
//    their value and the pipe shifts in 0.
//  - Valid pipe: 1 + SH_LAT stages. When its output is 1 at an edge, sh_b is
//    pushed into the result FIFO. The result FIFO cannot overflow (credits).
//  - Return: out_valid & out_ready at an edge pops the result FIFO and
//    increments credits.
//  - Credit invariant: credits + in-flight + result occupancy == RES_DEPTH.
//    Issue and return on the same edge leave credits unchanged.
//  - Minimum latency: accept at edge E0 -> out_valid = 1 after edge E0+2+SH_LAT.
//  - Throughput: 1 result/cycle sustained when out_ready stays high and
//    RES_DEPTH >= 2+SH_LAT.
//  - Order: results return strictly in acceptance order. No reordering, no drops.
//  - Boundaries:
//    - Cmd FIFO full: in_ready = 0. Push and pop on the same edge when full is
//      allowed: in_ready stays 0 that cycle and rises next cycle.
//    - Cmd FIFO empty: a command pushed at edge E is issuable at E+1, never at E
//      (no bypass).
//    - Credits = 0: issue stalls and sh_* hold their value.
//    - Pointers wrap modulo depth; full and empty are distinguished by an extra
//      pointer bit.
//    - in_amt = 0 is forwarded unchanged.
//    - out_data is undefined-but-stable when out_valid = 0; drive the head entry.
//    - Reset mid-operation: queued commands, in-flight commands and held results
//      are discarded; nothing is emitted after release until new accepts.
// STRUCTURE
//  - Package shift_pkg.vh: DATA_W = 32, AMT_W = 5, CMD_W = DATA_W+AMT_W+1,
//    field offsets for the packed command {rotate, amt, data}.
//  - Sub-module: shift_sync_fifo #(WIDTH, DEPTH). Synchronous FIFO with
//    clock/reset_n, push/pop, full/empty and a combinational head.
//    Instantiated twice: commands at CMD_W, results at DATA_W.
//  - Credit counter and valid pipe are local to this module.
// TESTING
//  The bench couples shift_issue_ctrl to a registered model: sh_b <= rotate ?
//  rotl(a, sel) : a << sel, with SH_LAT = 1.
//  1 Single command 0x0000001F, amt 1, rot 1, out_ready = 1 -> out_data
//    0x0000003E, out_valid high exactly 3 cycles after accept, for 1 cycle.
//  2 Rotate wrap: 0x80000001, amt 4, rot 1 -> 0x00000018. Same operand with
//    rot 0 -> 0x00000010.
//  3 Stream of 16 back-to-back commands, out_ready = 1 -> 16 in-order results
//    on consecutive cycles, in_ready never drops.
//  4 out_ready = 0, push 10 commands -> exactly 4 results held, credits 0,
//    in_ready = 0 after 4 queued commands, sh_* frozen. Then release out_ready
//    -> all 10 return in order.
//  5 Full cmd FIFO with simultaneous push and pop -> no loss or duplicate.
//    Scoreboard count matches.
//  6 Assert reset_n low with 3 commands queued and 2 in flight -> out_valid = 0,
//    busy = 0, in_ready = 1 immediately. After release, one new command
//    returns correctly and nothing stale appears.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths and command field layout for the shift issue stage
package shift_pkg;
    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    localparam int CMD_W  = DATA_W + AMT_W + 1;

    // Packed command layout: {rotate, amt, data}
    localparam int DATA_LSB = 0;
    localparam int AMT_LSB  = DATA_W;
    localparam int ROT_BIT  = DATA_W + AMT_W;
endpackage

// File: rtl/shift_sync_fifo.sv
// rtl/shift_sync_fifo.sv - synchronous FIFO with wrap-bit pointers and combinational head
module shift_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/shift_issue_ctrl.sv
// rtl/shift_issue_ctrl.sv - credit-based issue/return stage around a fixed-latency barrel shifter
module shift_issue_ctrl
    import shift_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int SH_LAT    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_rotate,
    output logic [DATA_W-1:0] sh_a,
    output logic [AMT_W-1:0]  sh_sel,
    output logic              sh_rotate,
    input  logic [DATA_W-1:0] sh_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);
    localparam int CW = $clog2(RES_DEPTH + 1);

    logic [CMD_W-1:0]  cmd_head;
    logic              cmd_full, cmd_empty;
    logic              res_full, res_empty;
    logic              issue, ret, res_push;

    logic [CW-1:0]     credit_q, credit_d;
    logic [SH_LAT:0]   vpipe_q, vpipe_d;
    logic [DATA_W-1:0] sh_a_q;
    logic [AMT_W-1:0]  sh_sel_q;
    logic              sh_rotate_q;

    shift_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (in_valid),
        .push_data ({in_rotate, in_amt, in_data}),
        .pop       (issue),
        .head      (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty)
    );

    shift_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (res_push),
        .push_data (sh_b),
        .pop       (ret),
        .head      (out_data),
        .full      (res_full),
        .empty     (res_empty)
    );

    // A command only leaves the queue once a result slot is reserved for it.
    assign issue     = ~cmd_empty & (credit_q != '0);
    assign ret       = ~res_empty & out_ready;
    assign res_push  = vpipe_q[SH_LAT];
    assign in_ready  = ~cmd_full;
    assign out_valid = ~res_empty;
    assign busy      = ~cmd_empty | (|vpipe_q) | ~res_empty;
    assign sh_a      = sh_a_q;
    assign sh_sel    = sh_sel_q;
    assign sh_rotate = sh_rotate_q;

    always_comb begin
        credit_d = credit_q;
        case ({issue, ret})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = issue;
        for (int i = 1; i <= SH_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            credit_q    <= CW'(RES_DEPTH);
            vpipe_q     <= '0;
            sh_a_q      <= '0;
            sh_sel_q    <= '0;
            sh_rotate_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
            vpipe_q  <= vpipe_d;
            if (issue) begin
                sh_a_q      <= cmd_head[DATA_LSB +: DATA_W];
                sh_sel_q    <= cmd_head[AMT_LSB +: AMT_W];
                sh_rotate_q <= cmd_head[ROT_BIT];
            end
        end
    end

    // The credit pool sizes the result FIFO, so a returning result always fits.
    assert property (@(posedge clock) disable iff (!reset_n) !(res_push && res_full));
endmodule

// File: tb/tb_shift_issue_ctrl.sv
// tb/tb_shift_issue_ctrl.sv - directed self-checking bench for shift_issue_ctrl
module tb_shift_issue_ctrl;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_rotate;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [31:0] sh_a, sh_b, out_data;
    logic [4:0]  sh_sel;
    logic        sh_rotate, out_valid, out_ready, busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_pop    = 0;
    int          ready_drops = 0;
    bit          watch_ready = 1'b0;
    bit          sender_done;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    shift_issue_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_rotate (in_rotate),
        .sh_a      (sh_a),
        .sh_sel    (sh_sel),
        .sh_rotate (sh_rotate),
        .sh_b      (sh_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [31:0] rotl(input logic [31:0] a, input logic [4:0] s);
        return (a << s) | (a >> (6'd32 - {1'b0, s}));
    endfunction

    // Registered shifter, one edge of latency.
    always @(posedge clock) sh_b <= sh_rotate ? rotl(sh_a, sh_sel) : (sh_a << sh_sel);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_rotate ? rotl(in_data, in_amt) : (in_data << in_amt));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) check_eq("unexpected_out", 32'(1), 32'(0));
                else                   check_eq("out_data", out_data, exp_q.pop_front());
            end
            if (watch_ready && !in_ready) ready_drops++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic r);
        bit acc = 1'b0;
        int cyc = 0;
        in_valid = 1'b1; in_data = d; in_amt = a; in_rotate = r;
        while (!acc && cyc < 300) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!acc) check_eq("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_out_valid(input string tag);
        int c = 0;
        @(negedge clock);
        while (!out_valid && c < 50) begin
            @(negedge clock);
            c++;
        end
        check_eq(tag, 32'(out_valid), 32'(1));
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((busy || exp_q.size() != 0) && c < 500) begin
            tick(1);
            c++;
        end
        check_eq("drain_busy", 32'(busy), 32'(0));
        check_eq("drain_sb", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic wait_sender();
        int c = 0;
        while (!sender_done && c < 500) begin
            tick(1);
            c++;
        end
        check_eq("sender_done", 32'(sender_done), 32'(1));
    endtask

    initial begin
        int base_acc, base_pop;
        reset_n = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_rotate = 1'b0; out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'(1));
        check_eq("rst_out_valid", 32'(out_valid), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_sh_a", sh_a, 32'h0);
        check_eq("rst_sh_sel", 32'(sh_sel), 32'(0));
        check_eq("rst_sh_rotate", 32'(sh_rotate), 32'(0));
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'(1));
        check_eq("post_rst_credits", 32'(dut.credit_q), 32'(4));

        // 1: single command, latency and one-cycle pulse
        out_ready = 1'b1;
        send(32'h0000001F, 5'd1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_eq("t1_latency", 32'(out_valid), 32'(i == 3));
            if (i == 3) check_eq("t1_data", out_data, 32'h0000003E);
        end
        tick(1);
        wait_drain();

        // 2: rotate wrap versus plain shift of the same operand
        send(32'h80000001, 5'd4, 1'b1);
        send(32'h80000001, 5'd4, 1'b0);
        wait_out_valid("t2_valid");
        check_eq("t2_rot", out_data, 32'h00000018);
        @(negedge clock);
        check_eq("t2_shl_valid", 32'(out_valid), 32'(1));
        check_eq("t2_shl", out_data, 32'h00000010);
        tick(1);
        wait_drain();

        // 3: 16 back-to-back commands
        base_pop = n_pop;
        ready_drops = 0;
        fork
            begin
                watch_ready = 1'b1;
                for (int i = 0; i < 16; i++)
                    send(32'hA5000000 + 32'(i) * 32'h01030507, 5'(i * 3), i[0]);
                watch_ready = 1'b0;
            end
            begin
                wait_out_valid("t3_first");
                for (int k = 0; k < 16; k++) begin
                    check_eq("t3_consecutive", 32'(out_valid), 32'(1));
                    @(negedge clock);
                end
            end
        join
        tick(1);
        check_eq("t3_in_ready_drops", 32'(ready_drops), 32'(0));
        wait_drain();
        check_eq("t3_count", 32'(n_pop - base_pop), 32'(16));

        // 4: consumer stalled, credits exhausted, issue frozen
        out_ready = 1'b0;
        base_acc = n_acc; base_pop = n_pop;
        sender_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(32'h00000100 + 32'(i), 5'(i + 1), i[0]);
                sender_done = 1'b1;
            end
        join_none
        tick(20);
        check_eq("t4_credits", 32'(dut.credit_q), 32'(0));
        check_eq("t4_out_valid", 32'(out_valid), 32'(1));
        check_eq("t4_in_ready", 32'(in_ready), 32'(0));
        check_eq("t4_accepted", 32'(n_acc - base_acc), 32'(8));
        check_eq("t4_sh_a", sh_a, 32'h00000103);
        check_eq("t4_sh_sel", 32'(sh_sel), 32'(4));
        check_eq("t4_sh_rotate", 32'(sh_rotate), 32'(1));
        tick(3);
        check_eq("t4_sh_a_frozen", sh_a, 32'h00000103);
        out_ready = 1'b1;
        wait_sender();
        wait_drain();
        check_eq("t4_returned", 32'(n_pop - base_pop), 32'(10));

        // 5: push offered while full on the same edge as a pop
        out_ready = 1'b0;
        base_acc = n_acc; base_pop = n_pop;
        sender_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 9; i++) send(32'h00000200 + 32'(i), 5'(31 - i), i[0]);
                sender_done = 1'b1;
            end
        join_none
        tick(20);
        out_ready = 1'b1;
        @(negedge clock);
        check_eq("t5_full_a", 32'(in_ready), 32'(0));
        @(negedge clock);
        check_eq("t5_full_b", 32'(in_ready), 32'(0));
        @(negedge clock);
        check_eq("t5_ready_rise", 32'(in_ready), 32'(1));
        tick(1);
        wait_sender();
        wait_drain();
        check_eq("t5_accepted", 32'(n_acc - base_acc), 32'(9));
        check_eq("t5_returned", 32'(n_pop - base_pop), 32'(9));

        // 6: reset with 3 queued, 2 in flight, 2 held
        out_ready = 1'b0;
        sender_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 9; i++) send(32'h00000300 + 32'(i), 5'(i), 1'b1);
                sender_done = 1'b1;
            end
        join_none
        tick(20);
        out_ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(posedge clock);
        #1;
        check_eq("t6_busy_before", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check_eq("t6_out_valid", 32'(out_valid), 32'(0));
        check_eq("t6_busy", 32'(busy), 32'(0));
        check_eq("t6_in_ready", 32'(in_ready), 32'(1));
        wait_sender();
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("t6_no_stale", 32'(out_valid), 32'(0));
        end
        tick(1);
        out_ready = 1'b1;
        base_pop = n_pop;
        send(32'hDEADBEEF, 5'd8, 1'b1);
        wait_out_valid("t6_new_valid");
        check_eq("t6_new_data", out_data, 32'hADBEEFDE);
        tick(1);
        wait_drain();
        check_eq("t6_returned", 32'(n_pop - base_pop), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
